mini_cpu_stack_vga: RTL and testbench

Parametrised 28-bit-instruction processor core for the VGA lab designs. It fetches from an external instruction ROM and executes through a two-stage fetch/execute pipeline. It holds an internal register file and a multi-level CALL/RET stack, and issues framebuffer pixel writes over a valid/ready port so that a slower video memory can stall it.

---
 rtl/mini_cpu_stack_vga_if.sv | 29 ++
 rtl/mini_cpu_stack_vga.sv | 164 ++++++++++++++++
 tb/tb_mini_cpu_stack_vga.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mini_cpu_stack_vga_if.sv
// Pixel write port of the mini CPU: the core drives a valid/ready request
// carrying column, row and colour; the video memory answers with ready.
interface mini_cpu_stack_vga_if #(
    parameter int VGA_X_WIDTH = 8,
    parameter int VGA_Y_WIDTH = 8,
    parameter int COLOR_WIDTH = 3
);
    logic                   oVgaValid;
    logic                   iVgaReady;
    logic [VGA_X_WIDTH-1:0] oVgaX;
    logic [VGA_Y_WIDTH-1:0] oVgaY;
    logic [COLOR_WIDTH-1:0] oVgaColor;

    modport master (
        output oVgaValid,
        output oVgaX,
        output oVgaY,
        output oVgaColor,
        input  iVgaReady
    );

    modport slave (
        input  oVgaValid,
        input  oVgaX,
        input  oVgaY,
        input  oVgaColor,
        output iVgaReady
    );
endinterface

// File: rtl/mini_cpu_stack_vga.sv
// Two-stage (fetch/execute) 28-bit mini CPU with register file, CALL/RET stack
// and a stallable pixel port. Define MINI_CPU_SMUL_EN to enable the SMUL opcode.
module mini_cpu_stack_vga #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int REG_COUNT   = 256,
    parameter int STACK_DEPTH = 4,
    parameter int VGA_X_WIDTH = 8,
    parameter int VGA_Y_WIDTH = 8,
    parameter int COLOR_WIDTH = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oInstrAddr,
    input  logic [27:0]           iInstruction,
    mini_cpu_stack_vga_if.master  vga,
    output logic [1:0]            oStackFault
);
    localparam int RIDX = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int SIW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_ADD = 4'd1, OP_SUB = 4'd2, OP_STO = 4'd3,
        OP_BLE  = 4'd4,  OP_BGE = 4'd5, OP_JMP = 4'd6, OP_SMUL = 4'd7,
        OP_CALL = 4'd8,  OP_RET = 4'd9, OP_VGA = 4'd10, OP_INC = 4'd11
    } opcode_e;

    logic [ADDR_WIDTH-1:0] ipReg, ipNext;
    logic [27:0]           irReg, irNext;
    logic [SPW-1:0]        spReg, spNext;
    logic [1:0]            faultReg, faultNext;

    logic [DATA_WIDTH-1:0] regFile [REG_COUNT];
    logic [ADDR_WIDTH-1:0] stackMem [STACK_DEPTH];

    opcode_e                 op;
    logic [RIDX-1:0]         destIdx, src1Idx, src0Idx;
    logic signed [DATA_WIDTH-1:0] srcA, srcB;
    logic signed [15:0]      imm16;
    logic [DATA_WIDTH-1:0]   immExt;
    logic [ADDR_WIDTH-1:0]   target, popAddr;
    logic [SIW-1:0]          pushIdx, popIdx;
    logic                    stall, taken, pushEn;
    logic                    wrEn, wrEnHi;
    logic [RIDX-1:0]         wrAddr, wrAddrHi;
    logic [DATA_WIDTH-1:0]   wrData, wrDataHi;

    assign op      = opcode_e'(irReg[27:24]);
    assign destIdx = irReg[16 +: RIDX];
    assign src1Idx = irReg[8 +: RIDX];
    assign src0Idx = irReg[0 +: RIDX];
    assign srcA    = regFile[src1Idx];
    assign srcB    = regFile[src0Idx];
    assign imm16   = irReg[15:0];
    assign immExt  = DATA_WIDTH'(imm16);
    assign target  = ADDR_WIDTH'(irReg[23:16]);
    assign pushIdx = SIW'(spReg);
    assign popIdx  = SIW'(spReg - 1'b1);
    assign popAddr = stackMem[popIdx];

`ifdef MINI_CPU_SMUL_EN
    logic signed [2*DATA_WIDTH-1:0] product;
    assign product = srcA * srcB;
`endif

    assign vga.oVgaValid = (op == OP_VGA);
    assign vga.oVgaX     = VGA_X_WIDTH'(srcA);
    assign vga.oVgaY     = VGA_Y_WIDTH'(srcB);
    assign vga.oVgaColor = COLOR_WIDTH'(irReg[23:16]);
    assign stall         = vga.oVgaValid && !vga.iVgaReady;
    assign oInstrAddr    = ipReg;
    assign oStackFault   = faultReg;

    always_comb begin
        ipNext    = ipReg + 1'b1;
        irNext    = iInstruction;
        spNext    = spReg;
        faultNext = faultReg;
        taken     = 1'b0;
        pushEn    = 1'b0;
        wrEn      = 1'b0;
        wrAddr    = destIdx;
        wrData    = '0;
        wrEnHi    = 1'b0;
        wrAddrHi  = destIdx + 1'b1;
        wrDataHi  = '0;
        case (op)
            OP_ADD: begin wrEn = 1'b1; wrData = srcA + srcB; end
            OP_SUB: begin wrEn = 1'b1; wrData = srcA - srcB; end
            OP_STO: begin wrEn = 1'b1; wrData = immExt; end
            OP_INC: begin wrEn = 1'b1; wrData = srcA + 1'b1; end
            OP_BLE: taken = (srcA <= srcB);
            OP_BGE: taken = (srcA >= srcB);
            OP_JMP: taken = 1'b1;
            OP_SMUL: begin
`ifdef MINI_CPU_SMUL_EN
                wrEn     = 1'b1;
                wrData   = product[DATA_WIDTH-1:0];
                wrEnHi   = 1'b1;
                wrDataHi = product[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
            end
            OP_CALL: begin
                // IP already points past the CALL, so it is the return address.
                if (spReg == SP_FULL) begin
                    faultNext[0] = 1'b1;
                end else begin
                    pushEn = 1'b1;
                    spNext = spReg + 1'b1;
                    taken  = 1'b1;
                end
            end
            OP_RET: begin
                if (spReg == '0) begin
                    faultNext[1] = 1'b1;
                end else begin
                    spNext = spReg - 1'b1;
                    taken  = 1'b1;
                end
            end
            default: ;
        endcase
        if (taken) begin
            ipNext = (op == OP_RET) ? popAddr : target;
            irNext = '0;
        end
        // Only a VGA op can stall, and it changes no other state.
        if (stall) begin
            ipNext = ipReg;
            irNext = irReg;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ipReg    <= '0;
            irReg    <= '0;
            spReg    <= '0;
            faultReg <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            ipReg    <= ipNext;
            irReg    <= irNext;
            spReg    <= spNext;
            faultReg <= faultNext;
            if (wrEn) begin
                regFile[wrAddr] <= wrData;
            end
            if (wrEnHi) begin
                regFile[wrAddrHi] <= wrDataHi;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && pushEn) begin
            stackMem[pushIdx] <= ipReg;
        end
    end
endmodule

// File: tb/tb_mini_cpu_stack_vga.sv
// Directed self-checking bench for mini_cpu_stack_vga: arithmetic, branches,
// call stack, pixel handshake, SMUL and reset during a stalled pixel.
module tb_mini_cpu_stack_vga;
    logic        Clock;
    logic        Reset;
    logic [15:0] instrAddr;
    logic [27:0] instruction;
    logic [1:0]  stackFault;
    logic [27:0] rom [256];
    int          errors;
    int          checks;

    mini_cpu_stack_vga_if #(.VGA_X_WIDTH(8), .VGA_Y_WIDTH(8), .COLOR_WIDTH(3)) vgaBus ();

    mini_cpu_stack_vga dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oInstrAddr   (instrAddr),
        .iInstruction (instruction),
        .vga          (vgaBus.master),
        .oStackFault  (stackFault)
    );

    assign instruction = rom[instrAddr[7:0]];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] enc(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
        return {4'd3, d, imm};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 28'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Returns at a falling edge with the core freshly reset (IP=0, IR=NOP).
    task automatic resetCpu();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        clearRom();
        rom[0] = sto(8'd1, 16'd77);
        vgaBus.iVgaReady = 1'b1;
        resetCpu();
        checks++; if (instrAddr !== 16'd0) begin errors++; $display("FAIL reset_ip: got %h want 0000", instrAddr); end
        checks++; if (vgaBus.oVgaValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vgaBus.oVgaValid); end
        checks++; if (stackFault !== 2'b00) begin errors++; $display("FAIL reset_fault: got %b want 00", stackFault); end
        checks++; if (dut.regFile[1] !== 16'd0) begin errors++; $display("FAIL reset_reg: got %h want 0000", dut.regFile[1]); end
        step(2);
        checks++; if (dut.regFile[1] !== 16'd77) begin errors++; $display("FAIL reset_first_instr: got %h want 004d", dut.regFile[1]); end
        $display("test_reset done");
    endtask

    task automatic test_arith();
        clearRom();
        rom[0] = sto(8'd1, 16'd5);
        rom[1] = sto(8'd2, 16'hFFFD);
        rom[2] = enc(4'd1, 8'd3, 8'd1, 8'd2);
        rom[3] = enc(4'd2, 8'd4, 8'd2, 8'd1);
        rom[4] = enc(4'd11, 8'd5, 8'd4, 8'd0);
        resetCpu();
        step(4);
        checks++; if (dut.regFile[3] !== 16'd2) begin errors++; $display("FAIL arith_add: got %h want 0002", dut.regFile[3]); end
        step(1);
        checks++; if (dut.regFile[4] !== 16'hFFF8) begin errors++; $display("FAIL arith_sub: got %h want fff8", dut.regFile[4]); end
        step(1);
        checks++; if (dut.regFile[5] !== 16'hFFF9) begin errors++; $display("FAIL arith_inc: got %h want fff9", dut.regFile[5]); end
        checks++; if (instrAddr !== 16'd6) begin errors++; $display("FAIL arith_throughput: got %h want 0006", instrAddr); end
        $display("test_arith done");
    endtask

    task automatic test_branch();
        clearRom();
        rom[0]     = sto(8'd1, 16'd4);
        rom[1]     = sto(8'd2, 16'd4);
        rom[2]     = enc(4'd4, 8'h20, 8'd1, 8'd2);
        rom[3]     = sto(8'd7, 16'd99);
        rom[8'h20] = sto(8'd8, 16'd1);
        rom[8'h21] = sto(8'd1, 16'd3);
        rom[8'h22] = enc(4'd5, 8'h40, 8'd1, 8'd2);
        rom[8'h23] = sto(8'd9, 16'd7);
        resetCpu();
        step(4);
        checks++; if (instrAddr !== 16'h0020) begin errors++; $display("FAIL ble_target: got %h want 0020", instrAddr); end
        step(4);
        checks++; if (instrAddr !== 16'h0024) begin errors++; $display("FAIL bge_not_taken: got %h want 0024", instrAddr); end
        step(1);
        checks++; if (dut.regFile[7] !== 16'd0) begin errors++; $display("FAIL ble_squash: got %h want 0000", dut.regFile[7]); end
        checks++; if (dut.regFile[8] !== 16'd1) begin errors++; $display("FAIL ble_dest_exec: got %h want 0001", dut.regFile[8]); end
        checks++; if (dut.regFile[9] !== 16'd7) begin errors++; $display("FAIL bge_fallthrough: got %h want 0007", dut.regFile[9]); end
        $display("test_branch done");
    endtask

    task automatic test_stack();
        logic [7:0] expIp [19];
        logic [1:0] expFault [19];
        expIp = '{8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h42,
                  8'h31, 8'h32, 8'h21, 8'h22, 8'h11, 8'h12, 8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 19; i++) expFault[i] = (i < 9) ? 2'b00 : ((i < 18) ? 2'b01 : 2'b11);
        clearRom();
        rom[8'h00] = enc(4'd8, 8'h10, 8'd0, 8'd0);
        rom[8'h10] = enc(4'd8, 8'h20, 8'd0, 8'd0);
        rom[8'h20] = enc(4'd8, 8'h30, 8'd0, 8'd0);
        rom[8'h30] = enc(4'd8, 8'h40, 8'd0, 8'd0);
        rom[8'h40] = enc(4'd8, 8'h50, 8'd0, 8'd0);
        rom[8'h41] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        rom[8'h31] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        rom[8'h21] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        rom[8'h11] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        rom[8'h01] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        resetCpu();
        for (int i = 0; i < 19; i++) begin
            step(1);
            checks++;
            if (instrAddr !== {8'h00, expIp[i]} || stackFault !== expFault[i]) begin
                errors++;
                $display("FAIL stack_step%0d: got ip=%h fault=%b want ip=%h fault=%b",
                         i + 1, instrAddr, stackFault, {8'h00, expIp[i]}, expFault[i]);
            end
        end
        $display("test_stack done");
    endtask

    task automatic test_vga();
        clearRom();
        rom[0] = sto(8'd1, 16'd10);
        rom[1] = sto(8'd2, 16'd20);
        rom[2] = enc(4'd10, 8'd5, 8'd1, 8'd2);
        rom[3] = sto(8'd3, 16'd1);
        vgaBus.iVgaReady = 1'b0;
        resetCpu();
        step(3);
        for (int c = 0; c < 4; c++) begin
            vgaBus.iVgaReady = (c == 3);
            checks++;
            if (vgaBus.oVgaValid !== 1'b1 || vgaBus.oVgaX !== 8'd10 || vgaBus.oVgaY !== 8'd20 ||
                vgaBus.oVgaColor !== 3'd5 || instrAddr !== 16'd3) begin
                errors++;
                $display("FAIL vga_stall_c%0d: got v=%b x=%0d y=%0d c=%0d ip=%h want v=1 x=10 y=20 c=5 ip=0003",
                         c, vgaBus.oVgaValid, vgaBus.oVgaX, vgaBus.oVgaY, vgaBus.oVgaColor, instrAddr);
            end
            step(1);
        end
        checks++; if (vgaBus.oVgaValid !== 1'b0 || instrAddr !== 16'd4) begin errors++; $display("FAIL vga_resume: got v=%b ip=%h want v=0 ip=0004", vgaBus.oVgaValid, instrAddr); end
        step(1);
        checks++; if (dut.regFile[3] !== 16'd1) begin errors++; $display("FAIL vga_after: got %h want 0001", dut.regFile[3]); end
        $display("test_vga done");
    endtask

    task automatic test_back_to_back();
        clearRom();
        rom[0] = sto(8'd1, 16'd3);
        rom[1] = enc(4'd10, 8'd2, 8'd1, 8'd1);
        rom[2] = enc(4'd10, 8'd7, 8'd1, 8'd0);
        vgaBus.iVgaReady = 1'b1;
        resetCpu();
        step(2);
        checks++; if (vgaBus.oVgaValid !== 1'b1 || vgaBus.oVgaColor !== 3'd2 || vgaBus.oVgaX !== 8'd3) begin errors++; $display("FAIL b2b_first: got v=%b c=%0d x=%0d want v=1 c=2 x=3", vgaBus.oVgaValid, vgaBus.oVgaColor, vgaBus.oVgaX); end
        step(1);
        checks++; if (vgaBus.oVgaValid !== 1'b1 || vgaBus.oVgaColor !== 3'd7 || vgaBus.oVgaY !== 8'd0) begin errors++; $display("FAIL b2b_second: got v=%b c=%0d y=%0d want v=1 c=7 y=0", vgaBus.oVgaValid, vgaBus.oVgaColor, vgaBus.oVgaY); end
        step(1);
        checks++; if (vgaBus.oVgaValid !== 1'b0 || instrAddr !== 16'd4) begin errors++; $display("FAIL b2b_nostall: got v=%b ip=%h want v=0 ip=0004", vgaBus.oVgaValid, instrAddr); end
        $display("test_back_to_back done");
    endtask

    task automatic test_smul();
        logic [31:0] prod;
        prod = 32'(-90000);
        clearRom();
        rom[0] = sto(8'd1, 16'd300);
        rom[1] = sto(8'd2, 16'hFED4);
        rom[2] = sto(8'd5, 16'h1234);
        rom[3] = enc(4'd7, 8'd5, 8'd1, 8'd2);
        vgaBus.iVgaReady = 1'b1;
        resetCpu();
        step(5);
`ifdef MINI_CPU_SMUL_EN
        checks++; if (dut.regFile[5] !== prod[15:0]) begin errors++; $display("FAIL smul_lo: got %h want %h", dut.regFile[5], prod[15:0]); end
        checks++; if (dut.regFile[6] !== prod[31:16]) begin errors++; $display("FAIL smul_hi: got %h want %h", dut.regFile[6], prod[31:16]); end
`else
        checks++; if (dut.regFile[5] !== 16'h1234) begin errors++; $display("FAIL smul_off_dest: got %h want 1234 (product %h ignored)", dut.regFile[5], prod); end
        checks++; if (dut.regFile[6] !== 16'h0000) begin errors++; $display("FAIL smul_off_hi: got %h want 0000", dut.regFile[6]); end
`endif
        $display("test_smul done");
    endtask

    task automatic test_reset_midstall();
        clearRom();
        rom[0] = enc(4'd9, 8'd0, 8'd0, 8'd0);
        rom[1] = sto(8'd1, 16'd10);
        rom[2] = enc(4'd10, 8'd4, 8'd1, 8'd1);
        vgaBus.iVgaReady = 1'b0;
        resetCpu();
        step(4);
        checks++; if (vgaBus.oVgaValid !== 1'b1 || stackFault !== 2'b10 || dut.regFile[1] !== 16'd10) begin errors++; $display("FAIL midstall_pre: got v=%b fault=%b r1=%h want v=1 fault=10 r1=000a", vgaBus.oVgaValid, stackFault, dut.regFile[1]); end
        Reset = 1'b0;
        step(1);
        checks++; if (vgaBus.oVgaValid !== 1'b0 || instrAddr !== 16'd0) begin errors++; $display("FAIL midstall_bus: got v=%b ip=%h want v=0 ip=0000", vgaBus.oVgaValid, instrAddr); end
        checks++; if (stackFault !== 2'b00 || dut.regFile[1] !== 16'd0) begin errors++; $display("FAIL midstall_state: got fault=%b r1=%h want fault=00 r1=0000", stackFault, dut.regFile[1]); end
        Reset = 1'b1;
        vgaBus.iVgaReady = 1'b1;
        $display("test_reset_midstall done");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Reset = 1'b0;
        vgaBus.iVgaReady = 1'b1;
        clearRom();
        test_reset();
        test_arith();
        test_branch();
        test_stack();
        test_vga();
        test_back_to_back();
        test_smul();
        test_reset_midstall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
